exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline. Consumes the ID/EXE pipeline register outputs and produces the values captured by the EXE/MEM register.
- Single-cycle ALU for most commands; iterative 32-cycle shift-add multiplier for MUL.
- Resolves branches and jumps, and drives the pipeline stall while a multiply is in flight.

Parameters:
- len, 32, width of pc/instruction buses.
- MUL_STEPS, 32, multiplier iterations (one operand bit per cycle).

Ports:
- clock  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high; clears FSM and multiplier registers.
- pc  input  len  PC+4 of the instruction in EXE.
- instruction  input  len  instruction word; [15:0] is the branch immediate.
- exe_cmd  input  4  ALU operation (encodings in package).
- branch_type  input  2  0 none, 1 BEZ, 2 BNE, 3 JMP.
- alu_inp1  input  32  operand A.
- alu_inp2  input  32  operand B (register or immediate, already muxed).
- reg2  input  32  rt value; BNE compare operand and store data.
- dest  input  5  writeback register index.
- kill  input  1  squash the current EXE instruction, including an in-flight MUL.
- alu_result  output  32  result for EXE/MEM.
- st_val  output  32  reg2 passed through.
- dest_out  output  5  dest passed through.
- branch_taken  output  1  redirect fetch and flush IF/ID and ID/EXE.
- branch_addr  output  len  redirect target.
- stall  output  1  freeze PC, IF/ID and ID/EXE; insert a bubble into EXE/MEM.

Behaviour:
- Single-cycle commands are purely combinational from the inputs:
  - ADD: A+B.
  - SUB: A-B.
  - AND, OR, NOR, XOR: bitwise.
  - SLL: A<<B[4:0].
  - SRA: arithmetic right shift by B[4:0].
  - SRL: logical right shift by B[4:0].
  - All arithmetic wraps modulo 2^32; no overflow flag.
- Unknown command: alu_result = 0, treated as single-cycle.
- Branch target for BEZ/BNE: pc + (sign_extend(instruction[15:0]) << 2), truncated to len.
- JMP target: same formula.
- BEZ taken when A==0. BNE taken when A!=reg2. JMP always taken.
- branch_taken is forced 0 when kill=1 and when exe_cmd=MUL.
- MUL FSM, state IDLE/BUSY/DONE, reset state IDLE:
  - IDLE & exe_cmd==MUL & !kill: latch multiplicand=A, multiplier=B, acc=0, count=0; stall=1 this cycle; next state BUSY.
  - BUSY, each cycle: if multiplier[0], acc+=multiplicand; then multiplicand<<=1, multiplier>>=1, count++. stall=1.
  - BUSY with count==MUL_STEPS-1: after that step, next state DONE.
  - DONE: stall=0, alu_result=acc (low 32 bits of the product, sign-agnostic); next state IDLE unconditionally. The upstream register advances on this edge, so a held MUL never restarts.
- Latency: MUL seen in cycle c; stall is high cycles c..c+32; result is valid in cycle c+33. Back-to-back MULs therefore cost 34 cycles each.
- kill in any state: next state IDLE, stall=0 in that same cycle, alu_result=0.
- reset mid-multiply: IDLE next edge and accumulator cleared.
- Reset values: stall=0, branch_taken=0. alu_result reflects the inputs (0 when ID/EXE is reset to zero).
- In IDLE/BUSY with exe_cmd==MUL, alu_result=0, so bubbles carry no stale data.
- st_val=reg2 and dest_out=dest are always combinational passthroughs.

Decomposition:
- Package exe_pkg holds:
  - EXE_ADD=4'b0000, EXE_SUB=4'b0010, EXE_AND=4'b0100, EXE_OR=4'b0101, EXE_NOR=4'b0110, EXE_XOR=4'b0111, EXE_SLL=4'b1000, EXE_SRA=4'b1001, EXE_SRL=4'b1010, EXE_MUL=4'b1100.
  - BR_NONE/BR_BEZ/BR_BNE/BR_JMP.
  - mul_state_t {IDLE, BUSY, DONE}.
- One sub-module, seq_multiplier: operands, start, kill in; busy, done, product out.
- ALU and branch unit stay inline in exe_stage.

Test Plan:
- Reset: reset=1 for 2 cycles with exe_cmd=MUL present → stall=0, FSM IDLE; release → stall rises the next cycle.
- ALU sweep: A=0x80000001, B=4 → ADD 0x80000005, SUB 0x7FFFFFFD, SRA 0xF8000000, SRL 0x08000000, SLL 0x00000010, NOR 0x7FFFFFFA.
- MUL: A=0xFFFFFFFD (-3), B=7 held by a stalled upstream → stall high exactly 33 cycles; cycle 34 alu_result=0xFFFFFFEB, stall=0; FSM returns to IDLE.
- Branches at pc=0x100:
  - BEZ, A=0, imm=0xFFFE → branch_taken=1, addr=0xF8.
  - BNE, A=5, reg2=5 → branch_taken=0.
  - JMP, imm=0x0010 → branch_taken=1, addr=0x140.
- kill at BUSY cycle 10 → stall=0 the same cycle, IDLE next; a following ADD 2+3 gives 5 with no stall.
- reset asserted at BUSY cycle 20 → IDLE, stall=0 after the edge; a new MUL 6×7 yields 42 after 33 stall cycles.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, branch kinds and
// multiplier FSM states.
package exe_pkg;

    localparam logic [3:0] EXE_ADD = 4'b0000;
    localparam logic [3:0] EXE_SUB = 4'b0010;
    localparam logic [3:0] EXE_AND = 4'b0100;
    localparam logic [3:0] EXE_OR  = 4'b0101;
    localparam logic [3:0] EXE_NOR = 4'b0110;
    localparam logic [3:0] EXE_XOR = 4'b0111;
    localparam logic [3:0] EXE_SLL = 4'b1000;
    localparam logic [3:0] EXE_SRA = 4'b1001;
    localparam logic [3:0] EXE_SRL = 4'b1010;
    localparam logic [3:0] EXE_MUL = 4'b1100;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEZ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;
    localparam logic [1:0] BR_JMP  = 2'd3;

    typedef logic [1:0] mul_state_t;
    localparam mul_state_t IDLE = 2'd0;
    localparam mul_state_t BUSY = 2'd1;
    localparam mul_state_t DONE = 2'd2;

endpackage

// File: rtl/exe_if.sv
// ID/EXE inputs and EXE/MEM-bound outputs of the execute stage.
interface exe_if #(parameter int len = 32);
    logic [len-1:0] pc;
    logic [len-1:0] instruction;
    logic [3:0]     exe_cmd;
    logic [1:0]     branch_type;
    logic [31:0]    alu_inp1;
    logic [31:0]    alu_inp2;
    logic [31:0]    reg2;
    logic [4:0]     dest;
    logic           kill;
    logic [31:0]    alu_result;
    logic [31:0]    st_val;
    logic [4:0]     dest_out;
    logic           branch_taken;
    logic [len-1:0] branch_addr;
    logic           stall;

    modport master (
        output pc, instruction, exe_cmd, branch_type, alu_inp1, alu_inp2, reg2, dest, kill,
        input  alu_result, st_val, dest_out, branch_taken, branch_addr, stall
    );
    modport slave (
        input  pc, instruction, exe_cmd, branch_type, alu_inp1, alu_inp2, reg2, dest, kill,
        output alu_result, st_val, dest_out, branch_taken, branch_addr, stall
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; returns the
// low 32 bits of the product one cycle after the last step.
module seq_multiplier
    import exe_pkg::*;
#(
    parameter int MUL_STEPS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        kill,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    mul_state_t    state_q, state_d;
    logic [31:0]   mcand_q, mcand_d;
    logic [31:0]   mplier_q, mplier_d;
    logic [31:0]   acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        case (state_q)
            IDLE: if (start) begin
                mcand_d  = a;
                mplier_d = b;
                acc_d    = '0;
                count_d  = '0;
                state_d  = BUSY;
            end
            BUSY: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == CW'(MUL_STEPS - 1)) state_d = DONE;
            end
            // upstream advances as DONE ends, so no restart check is needed here
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign busy    = !kill && ((state_q == IDLE && start) || state_q == BUSY);
    assign done    = !kill && state_q == DONE;
    assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, branch resolution and a sequential
// multiplier that holds the front of the pipeline while it runs.
module exe_stage
    import exe_pkg::*;
#(
    parameter int len       = 32,
    parameter int MUL_STEPS = 32
) (
    input logic  clock,
    input logic  reset,
    exe_if.slave bus
);

    logic           is_mul;
    logic           mul_busy, mul_done;
    logic [31:0]    mul_product;
    logic [31:0]    a, b;
    logic [31:0]    alu_val;
    logic [len-1:0] br_off;
    logic           br_cond;
    logic           unused_instr;

    assign a      = bus.alu_inp1;
    assign b      = bus.alu_inp2;
    assign is_mul = (bus.exe_cmd == EXE_MUL);

    seq_multiplier #(.MUL_STEPS(MUL_STEPS)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (is_mul && !bus.kill),
        .kill    (bus.kill),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_val = '0;
        case (bus.exe_cmd)
            EXE_ADD: alu_val = a + b;
            EXE_SUB: alu_val = a - b;
            EXE_AND: alu_val = a & b;
            EXE_OR:  alu_val = a | b;
            EXE_NOR: alu_val = ~(a | b);
            EXE_XOR: alu_val = a ^ b;
            EXE_SLL: alu_val = a << b[4:0];
            EXE_SRA: alu_val = $signed(a) >>> b[4:0];
            EXE_SRL: alu_val = a >> b[4:0];
            default: alu_val = '0;
        endcase
        // the finished product overrides whatever command sits in EXE
        if (mul_done) alu_val = mul_product;
        if (bus.kill) alu_val = '0;
    end

    always_comb begin
        br_cond = 1'b0;
        case (bus.branch_type)
            BR_BEZ:  br_cond = (a == 32'd0);
            BR_BNE:  br_cond = (a != bus.reg2);
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_off = {{(len - 18){bus.instruction[15]}}, bus.instruction[15:0], 2'b00};

    assign bus.alu_result   = alu_val;
    assign bus.st_val       = bus.reg2;
    assign bus.dest_out     = bus.dest;
    assign bus.branch_addr  = bus.pc + br_off;
    assign bus.branch_taken = br_cond && !bus.kill && !is_mul && !reset;
    assign bus.stall        = mul_busy && !reset;

    assign unused_instr = &{1'b0, bus.instruction[len-1:16]};

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a cycle-count/product model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_exe_stage;
    import exe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    exe_if #(.len(32)) bus ();

    exe_stage #(.len(32), .MUL_STEPS(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        sx = x;
        case (c)
            EXE_ADD: return x + y;
            EXE_SUB: return x - y;
            EXE_AND: return x & y;
            EXE_OR:  return x | y;
            EXE_NOR: return ~(x | y);
            EXE_XOR: return x ^ y;
            EXE_SLL: return x << y[4:0];
            EXE_SRA: return sx >>> y[4:0];
            EXE_SRL: return x >> y[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Model: mcyc = 0 idle, 1..32 busy cycles, 33 result cycle.
    int          mcyc = 0;
    logic [31:0] mprod = 0;

    always @(negedge clk) begin
        logic        mulc, cond, e_stall, e_taken;
        logic [31:0] e_alu, e_addr;
        if (chk_en) begin
            mulc = (bus.exe_cmd == EXE_MUL);
            if (bus.kill) begin
                e_stall = 0; e_alu = 0;
            end else if (mcyc == 33) begin
                e_stall = 0; e_alu = mprod;
            end else begin
                e_stall = mulc;
                if (mcyc > 0) e_stall = 1;
                e_alu = mulc ? 32'd0 : alu_ref(bus.exe_cmd, bus.alu_inp1, bus.alu_inp2);
            end
            if (rst) e_stall = 0;
            case (bus.branch_type)
                BR_BEZ:  cond = (bus.alu_inp1 == 0);
                BR_BNE:  cond = (bus.alu_inp1 != bus.reg2);
                BR_JMP:  cond = 1;
                default: cond = 0;
            endcase
            e_taken = cond && !bus.kill && !mulc && !rst;
            e_addr  = bus.pc + 32'(int'($signed(bus.instruction[15:0])) * 4);
            check("m_stall", {31'd0, bus.stall}, {31'd0, e_stall});
            check("m_alu", bus.alu_result, e_alu);
            check("m_taken", {31'd0, bus.branch_taken}, {31'd0, e_taken});
            check("m_addr", bus.branch_addr, e_addr);
            check("m_st_val", bus.st_val, bus.reg2);
            check("m_dest", {27'd0, bus.dest_out}, {27'd0, bus.dest});
            if (rst || bus.kill) mcyc = 0;
            else if (mcyc == 0 && mulc) begin
                mcyc  = 1;
                mprod = bus.alu_inp1 * bus.alu_inp2;
            end else if (mcyc >= 1 && mcyc < 33) mcyc++;
            else mcyc = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        bus.exe_cmd = c; bus.alu_inp1 = x; bus.alu_inp2 = y; bus.branch_type = BR_NONE;
    endtask

    task automatic mul_wait(input string nm, input logic [31:0] exp);
        int n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!bus.stall) break;
            n++;
            cyc();
        end
        check({nm, "_stall_cycles"}, 32'(n), 32'd33);
        check({nm, "_result"}, bus.alu_result, exp);
        check({nm, "_stall_low"}, {31'd0, bus.stall}, 32'd0);
    endtask

    logic [3:0]  sw_cmd [9] = '{EXE_ADD, EXE_SUB, EXE_SRA, EXE_SRL, EXE_SLL, EXE_NOR, EXE_AND, EXE_XOR, 4'b1111};
    logic [31:0] sw_exp [9] = '{32'h80000005, 32'h7FFFFFFD, 32'hF8000000, 32'h08000000,
                                32'h00000010, 32'h7FFFFFFA, 32'h00000000, 32'h80000005, 32'h00000000};

    initial begin
        rst = 1;
        bus.pc = 0; bus.instruction = 0; bus.reg2 = 0; bus.dest = 0; bus.kill = 0;
        set_op(EXE_MUL, 32'd5, 32'd6);
        cyc();
        chk_en = 1;
        @(negedge clk);
        check("reset_stall", {31'd0, bus.stall}, 32'd0);
        check("reset_taken", {31'd0, bus.branch_taken}, 32'd0);
        cyc();
        rst = 0;
        @(negedge clk);
        check("release_stall", {31'd0, bus.stall}, 32'd1);
        cyc();
        bus.kill = 1;
        @(negedge clk);
        check("kill_clear_stall", {31'd0, bus.stall}, 32'd0);
        cyc();
        bus.kill = 0;

        bus.reg2 = 32'hCAFE0001; bus.dest = 5'd17;
        for (int i = 0; i < 9; i++) begin
            set_op(sw_cmd[i], 32'h80000001, 32'd4);
            @(negedge clk);
            check($sformatf("alu_%0d", i), bus.alu_result, sw_exp[i]);
            cyc();
        end
        check("st_val", bus.st_val, 32'hCAFE0001);

        bus.pc = 32'h100;
        set_op(EXE_ADD, 0, 0); bus.branch_type = BR_BEZ; bus.instruction = 32'h0000FFFE;
        @(negedge clk);
        check("bez_taken", {31'd0, bus.branch_taken}, 32'd1);
        check("bez_addr", bus.branch_addr, 32'hF8);
        cyc();
        set_op(EXE_ADD, 5, 0); bus.branch_type = BR_BNE; bus.reg2 = 5;
        @(negedge clk);
        check("bne_equal", {31'd0, bus.branch_taken}, 32'd0);
        cyc();
        set_op(EXE_ADD, 0, 0); bus.branch_type = BR_JMP; bus.instruction = 32'h00000010;
        @(negedge clk);
        check("jmp_taken", {31'd0, bus.branch_taken}, 32'd1);
        check("jmp_addr", bus.branch_addr, 32'h140);
        cyc();
        bus.kill = 1;
        @(negedge clk);
        check("jmp_killed", {31'd0, bus.branch_taken}, 32'd0);
        cyc();
        bus.kill = 0;

        set_op(EXE_MUL, 32'hFFFFFFFD, 32'd7);
        mul_wait("mul_neg", 32'hFFFFFFEB);
        cyc();
        set_op(EXE_ADD, 1, 1);
        @(negedge clk);
        check("post_mul_idle", {31'd0, bus.stall}, 32'd0);
        cyc();

        set_op(EXE_MUL, 9, 9);
        repeat (10) cyc();
        bus.kill = 1;
        @(negedge clk);
        check("kill_busy_stall", {31'd0, bus.stall}, 32'd0);
        check("kill_busy_alu", bus.alu_result, 32'd0);
        cyc();
        bus.kill = 0;
        set_op(EXE_ADD, 2, 3);
        @(negedge clk);
        check("after_kill_add", bus.alu_result, 32'd5);
        check("after_kill_stall", {31'd0, bus.stall}, 32'd0);
        cyc();

        set_op(EXE_MUL, 100, 3);
        repeat (20) cyc();
        rst = 1;
        @(negedge clk);
        check("rst_busy_stall", {31'd0, bus.stall}, 32'd0);
        cyc();
        rst = 0;
        set_op(EXE_ADD, 0, 0);
        @(negedge clk);
        check("after_rst_stall", {31'd0, bus.stall}, 32'd0);
        cyc();
        set_op(EXE_MUL, 6, 7);
        mul_wait("mul_6x7", 32'd42);
        cyc();
        set_op(EXE_ADD, 0, 0);
        cyc();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
